// File: rtl/sirv_rstgen_pkg.sv
// Shared definitions for the always-on reset generator: FSM state
// encoding, reset-cause codes and the cause priority helper.
package sirv_rstgen_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } rstgen_state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_ERST = 2'd1;
    localparam logic [1:0] CAUSE_WDOG = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    // Only meaningful when some request is active. Watchdog beats
    // external, and software is what remains when neither is set.
    function automatic logic [1:0] pick_cause(input logic wdog, input logic erst);
        logic [1:0] c;
        if (wdog) begin
            c = CAUSE_WDOG;
        end else if (erst) begin
            c = CAUSE_ERST;
        end else begin
            c = CAUSE_SW;
        end
        return c;
    endfunction

endpackage

// File: rtl/sirv_gnrl_sync.sv
// Two-flop synchronizer with a configurable reset value.
// Compiled only when SIRV_RSTGEN_ERST_SYNC_EN is defined, since the
// reset generator is its only user and needs it only in that build.
`ifdef SIRV_RSTGEN_ERST_SYNC_EN
module sirv_gnrl_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic stage1;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule
`endif

// File: rtl/sirv_rstgen.sv
// Always-on reset generator. Merges the watchdog request, the external
// reset pin and the software pulse into a stretched core reset, clears
// the watchdog's sticky request and records the last reset cause.
// Define SIRV_RSTGEN_ERST_SYNC_EN to pass erst_n through a 2-flop
// synchronizer; otherwise erst_n must already be synchronous to clk.
module sirv_rstgen
    import sirv_rstgen_pkg::*;
#(
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdog_rst,
    input  logic       erst_n,
    input  logic       sw_rst_req,
    output logic       core_rst_n,
    output logic       wdog_clr,
    output logic [1:0] cause,
    output logic       busy
);

    // HOLD leaves on the cycle cnt reaches this value, so cnt never wraps.
    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

    rstgen_state_e state;
    logic [7:0]    cnt;
    logic          erst_q;
    logic          req;

`ifdef SIRV_RSTGEN_ERST_SYNC_EN
    logic erst_n_sync;

    sirv_gnrl_sync #(
        .RST_VAL (1'b1)
    ) u_erst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (erst_n),
        .q     (erst_n_sync)
    );

    assign erst_q = ~erst_n_sync;
`else
    assign erst_q = ~erst_n;
`endif

    assign req  = wdog_rst | erst_q | sw_rst_req;
    assign busy = ~core_rst_n;

    // Reset FSM: any request (re)starts HOLD, then one WAIT cycle lets the
    // watchdog leave reset before the core does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            cnt        <= 8'd0;
            cause      <= CAUSE_POR;
            core_rst_n <= 1'b0;
            wdog_clr   <= 1'b1;
        end else if (req) begin
            state      <= ST_HOLD;
            cnt        <= 8'd0;
            cause      <= pick_cause(wdog_rst, erst_q);
            core_rst_n <= 1'b0;
            wdog_clr   <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == CNT_LAST) begin
                        state    <= ST_WAIT;
                        wdog_clr <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    state      <= ST_RUN;
                    core_rst_n <= 1'b1;
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state      <= ST_HOLD;
                    cnt        <= 8'd0;
                    core_rst_n <= 1'b0;
                    wdog_clr   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sirv_rstgen.sv
// Directed testbench for sirv_rstgen with HOLD_CYCLES=16.
// Works with SIRV_RSTGEN_ERST_SYNC_EN defined or undefined.
module tb_sirv_rstgen;

    localparam int HOLD = 16;
`ifdef SIRV_RSTGEN_ERST_SYNC_EN
    localparam int ERST_LAT = 2;
`else
    localparam int ERST_LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wdog_rst;
    logic       erst_n;
    logic       sw_rst_req;
    logic       core_rst_n;
    logic       wdog_clr;
    logic [1:0] cause;
    logic       busy;

    int checks;
    int failures;

    sirv_rstgen #(
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wdog_rst   (wdog_rst),
        .erst_n     (erst_n),
        .sw_rst_req (sw_rst_req),
        .core_rst_n (core_rst_n),
        .wdog_clr   (wdog_clr),
        .cause      (cause),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the next rising edge sample them,
    // and return 1 ns after that edge.
    task automatic applyStimulus(input logic w, input logic e, input logic s);
        wdog_rst   = w;
        erst_n     = e;
        sw_rst_req = s;
        @(posedge clk);
        #1;
    endtask

    // Idle until core reset releases; report edges to wdog_clr low and to
    // core_rst_n high, or -1 if the bound expires.
    task automatic waitRun(output int clrEdge, output int runEdge);
        clrEdge = -1;
        runEdge = -1;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (clrEdge < 0 && wdog_clr == 1'b0) clrEdge = i;
            if (core_rst_n == 1'b1) begin
                runEdge = i;
                break;
            end
        end
    endtask

    initial begin
        int clrE;
        int runE;
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        wdog_rst   = 1'b0;
        erst_n     = 1'b1;
        sw_rst_req = 1'b0;

        // Reset state
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("por_core", 32'(core_rst_n), 0);
        checkOutput("por_clr", 32'(wdog_clr), 1);
        checkOutput("por_cause", 32'(cause), 0);
        checkOutput("por_busy", 32'(busy), 1);
        checkOutput("por_cnt", 32'(dut.cnt), 0);

        // Power-on release: wdog_clr falls at edge 16, core at edge 17
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("pon_core_e%0d", k), 32'(core_rst_n), (k >= 17) ? 1 : 0);
            checkOutput($sformatf("pon_clr_e%0d", k), 32'(wdog_clr), (k < 16) ? 1 : 0);
        end
        checkOutput("pon_cause", 32'(cause), 0);
        checkOutput("pon_busy", 32'(busy), 0);

        // Watchdog request held for three sampled edges
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("wdog_core", 32'(core_rst_n), 0);
        checkOutput("wdog_clr_on", 32'(wdog_clr), 1);
        checkOutput("wdog_cause", 32'(cause), 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitRun(clrE, runE);
        checkOutput("wdog_clr_fall", 32'(clrE), 16);
        checkOutput("wdog_release", 32'(runE), 17);
        checkOutput("wdog_cause_run", 32'(cause), 2);

        // Simultaneous software and watchdog: watchdog wins
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("both_cause", 32'(cause), 2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("both_cause_hold", 32'(cause), 2);
        waitRun(clrE, runE);
        checkOutput("both_release", 32'(runE), 17);

        // Lone software pulse
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("sw_core", 32'(core_rst_n), 0);
        checkOutput("sw_cause", 32'(cause), 3);
        waitRun(clrE, runE);
        checkOutput("sw_release", 32'(runE), 17);

        // External reset held low for 40 edges
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (k == ERST_LAT && ERST_LAT > 0)
                checkOutput("erst_pre", 32'(core_rst_n), 1);
            if (k == ERST_LAT + 1)
                checkOutput("erst_fall", 32'(core_rst_n), 0);
        end
        checkOutput("erst_cause", 32'(cause), 1);
        waitRun(clrE, runE);
        checkOutput("erst_clr_fall", 32'(clrE), 16 + ERST_LAT);
        checkOutput("erst_release", 32'(runE), 17 + ERST_LAT);

        // Software pulse restarts the count at cnt=10 and again in WAIT
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rst_cnt10", 32'(dut.cnt), 10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_cnt0", 32'(dut.cnt), 0);
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rst_hold_clr", 32'(wdog_clr), 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("rst_wait_clr", 32'(wdog_clr), 0);
        checkOutput("rst_wait_core", 32'(core_rst_n), 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rst_rehold_clr", 32'(wdog_clr), 1);
        checkOutput("rst_rehold_core", 32'(core_rst_n), 0);
        waitRun(clrE, runE);
        checkOutput("rst_release", 32'(runE), 17);
        checkOutput("rst_cause", 32'(cause), 3);

        // Async reset mid-HOLD
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("ahold_core", 32'(core_rst_n), 0);
        checkOutput("ahold_clr", 32'(wdog_clr), 1);
        checkOutput("ahold_cause", 32'(cause), 0);
        checkOutput("ahold_cnt", 32'(dut.cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitRun(clrE, runE);
        checkOutput("ahold_release", 32'(runE), 17);

        // Async reset mid-RUN after a software reset set the cause
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitRun(clrE, runE);
        checkOutput("arun_pre_cause", 32'(cause), 3);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("arun_core", 32'(core_rst_n), 0);
        checkOutput("arun_clr", 32'(wdog_clr), 1);
        checkOutput("arun_cause", 32'(cause), 0);
        checkOutput("arun_busy", 32'(busy), 1);
        checkOutput("arun_cnt", 32'(dut.cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
